// File: rtl/demux_reg4_if.sv
// demux_reg4_if: producer/consumer bus of the registered 1:4 demultiplexer
interface demux_reg4_if #(parameter int WIDTH = 4, parameter int CNT_W = 8);
  logic [WIDTH-1:0] x;
  logic [1:0]       s;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ack;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic [3:0]       y_valid;
  logic [CNT_W-1:0] drop_cnt;
  modport master (output x, s, in_valid, ack, input in_ready, y0, y1, y2, y3, y_valid, drop_cnt);
  modport slave  (input x, s, in_valid, ack, output in_ready, y0, y1, y2, y3, y_valid, drop_cnt);
endinterface

// File: rtl/demux_reg4.sv
// demux_reg4: registered 1:4 demultiplexer with per-channel valid/ack and saturating drop counter
module demux_reg4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         rst,
  demux_reg4_if.slave bus
);
  typedef enum logic {EMPTY, FULL} ch_st_t;
  ch_st_t           r_st [4];
  ch_st_t           w_st_nxt [4];
  logic [WIDTH-1:0] r_y [4];
  logic [WIDTH-1:0] w_y_nxt [4];
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       w_v;
  logic [1:0]       w_t;
  logic             w_ready, w_wr, w_drop;
  // s bits are swapped to match the companion mux: 10 -> y1, 01 -> y2
  assign w_t     = {bus.s[0], bus.s[1]};
  assign w_ready = ~w_v[w_t] | bus.ack[w_t];
  assign w_wr    = bus.in_valid & w_ready;
  assign w_drop  = bus.in_valid & ~w_ready;
  always_comb begin
    for (int i = 0; i < 4; i++) w_v[i] = (r_st[i] == FULL);
  end
  // acks are applied first so a same-channel write overrides them
  always_comb begin
    w_st_nxt  = r_st;
    w_y_nxt   = r_y;
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < 4; i++) if (bus.ack[i]) w_st_nxt[i] = EMPTY;
    if (w_wr) begin
      w_st_nxt[w_t] = FULL;
      w_y_nxt[w_t]  = bus.x;
    end
    if (w_drop && r_cnt != '1) w_cnt_nxt = r_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_st[i] <= EMPTY;
        r_y[i]  <= '0;
      end
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_y   <= w_y_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end
  assign bus.in_ready = w_ready;
  assign bus.y0       = r_y[0];
  assign bus.y1       = r_y[1];
  assign bus.y2       = r_y[2];
  assign bus.y3       = r_y[3];
  assign bus.y_valid  = w_v;
  assign bus.drop_cnt = r_cnt;
endmodule

// File: tb/tb_demux_reg4.sv
// tb_demux_reg4: directed and randomized checks of demux_reg4 against a behavioural model
module tb_demux_reg4;
  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0, n_tot = 0;
  bit   chk_en = 1'b0;
  demux_reg4_if #(.WIDTH(4), .CNT_W(8)) bus ();
  demux_reg4 #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int map [4] = '{0, 2, 1, 3};
  int m_y [4];
  bit m_v [4];
  int m_cnt;
  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // model: channel array plus counter, updated on each clock from the stimulus
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_y[i] = 0; m_v[i] = 0; end
      m_cnt = 0;
    end else begin
      int t;
      bit rdy;
      t   = map[bus.s];
      rdy = !m_v[t] || bus.ack[t];
      for (int i = 0; i < 4; i++) if (bus.ack[i]) m_v[i] = 0;
      if (bus.in_valid) begin
        if (rdy) begin m_y[t] = int'(bus.x); m_v[t] = 1; end
        else if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      int t, vv;
      t  = map[bus.s];
      vv = 0;
      for (int i = 0; i < 4; i++) vv += int'(m_v[i]) << i;
      chk("in_ready", int'(bus.in_ready), int'(!m_v[t] || bus.ack[t]));
      chk("y0", int'(bus.y0), m_y[0]);
      chk("y1", int'(bus.y1), m_y[1]);
      chk("y2", int'(bus.y2), m_y[2]);
      chk("y3", int'(bus.y3), m_y[3]);
      chk("y_valid", int'(bus.y_valid), vv);
      chk("drop_cnt", int'(bus.drop_cnt), m_cnt);
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit v, input logic [1:0] s, input logic [3:0] x, input logic [3:0] a);
    bus.in_valid = v; bus.s = s; bus.x = x; bus.ack = a;
    cyc();
  endtask
  initial begin
    rst = 1'b1;
    bus.in_valid = 0; bus.s = 0; bus.x = 0; bus.ack = 0;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst y_valid", int'(bus.y_valid), 0);
    chk("rst drop_cnt", int'(bus.drop_cnt), 0);
    rst = 1'b0;
    drive(1, 2'b10, 4'hA, 4'h0);
    chk("t1 y1", int'(bus.y1), 'hA);
    chk("t1 y_valid", int'(bus.y_valid), 'b0010);
    chk("t1 y0", int'(bus.y0), 0);
    drive(0, 2'b00, 4'h0, 4'hF);
    drive(1, 2'b00, 4'h1, 4'h0);
    drive(1, 2'b10, 4'h2, 4'h0);
    drive(1, 2'b01, 4'h3, 4'h0);
    drive(1, 2'b11, 4'h4, 4'h0);
    chk("t2 y0", int'(bus.y0), 1);
    chk("t2 y1", int'(bus.y1), 2);
    chk("t2 y2", int'(bus.y2), 3);
    chk("t2 y3", int'(bus.y3), 4);
    chk("t2 y_valid", int'(bus.y_valid), 'hF);
    bus.in_valid = 1; bus.s = 2'b01; bus.x = 4'h7; bus.ack = 4'h0;
    #1 chk("t3 in_ready full", int'(bus.in_ready), 0);
    cyc();
    chk("t3 y2 kept", int'(bus.y2), 3);
    chk("t3 drop", int'(bus.drop_cnt), 1);
    bus.ack = 4'b0100;
    #1 chk("t3 in_ready ack", int'(bus.in_ready), 1);
    cyc();
    chk("t3 y2 new", int'(bus.y2), 7);
    chk("t3 y_valid", int'(bus.y_valid), 'hF);
    chk("t3 drop kept", int'(bus.drop_cnt), 1);
    drive(0, 2'b00, 4'h0, 4'b0001);
    chk("t4 y_valid", int'(bus.y_valid), 'hE);
    chk("t4 y0 held", int'(bus.y0), 1);
    drive(0, 2'b00, 4'h0, 4'b0100);
    drive(0, 2'b00, 4'h0, 4'b0100);
    chk("t4 empty ack y_valid", int'(bus.y_valid), 'hA);
    chk("t4 empty ack y2", int'(bus.y2), 7);
    for (int i = 0; i < 300; i++) drive(1, 2'b10, 4'(i), 4'h0);
    chk("t5 saturate", int'(bus.drop_cnt), 255);
    drive(1, 2'b00, 4'h5, 4'h0);
    drive(1, 2'b01, 4'h6, 4'h0);
    chk("t6 pre y_valid", int'(bus.y_valid), 'hF);
    rst = 1'b1;
    drive(1, 2'b11, 4'h9, 4'h0);
    rst = 1'b0;
    chk("t6 y_valid", int'(bus.y_valid), 0);
    chk("t6 drop", int'(bus.drop_cnt), 0);
    chk("t6 y3", int'(bus.y3), 0);
    drive(1, 2'b10, 4'hA, 4'h0);
    chk("t6 y1", int'(bus.y1), 'hA);
    chk("t6 post y_valid", int'(bus.y_valid), 'b0010);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] a;
      a = 4'($urandom);
      if ($urandom_range(0, 2) != 0) a = 4'h0;
      rst = ($urandom_range(0, 199) == 0);
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom), a);
    end
    rst = 1'b0;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
